noc_network_interface: RTL and testbench

Per-processor injection stage that sits between one processor's 11-bit configure word and the local port of its mesh router. It detects send requests, queues them in a small FIFO, and formats them into 18-bit flits carrying destination, source, sequence number and parity. It presents the flits to the router under a valid/ready handshake. It also drives the processor-ready signal and honours the global block_all_paths stall.

---
 rtl/noc_pkg.sv | 41 ++++
 rtl/noc_sync_fifo.sv | 52 +++++
 rtl/noc_network_interface.sv | 93 +++++++++
 tb/tb_noc_network_interface.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: widths, flit/configure field positions, node IDs and flit packing.
package noc_pkg;

    localparam int unsigned FLIT_W  = 18;
    localparam int unsigned CFG_W   = 11;
    localparam int unsigned ENTRY_W = 10;  // queued {dest, payload}

    // Flit field positions
    localparam int unsigned FLIT_VALID      = 17;
    localparam int unsigned FLIT_DEST_HI    = 16;
    localparam int unsigned FLIT_DEST_LO    = 15;
    localparam int unsigned FLIT_SRC_HI     = 14;
    localparam int unsigned FLIT_SRC_LO     = 13;
    localparam int unsigned FLIT_SEQ_HI     = 12;
    localparam int unsigned FLIT_SEQ_LO     = 9;
    localparam int unsigned FLIT_PARITY     = 8;
    localparam int unsigned FLIT_PAYLOAD_HI = 7;
    localparam int unsigned FLIT_PAYLOAD_LO = 0;

    // Node IDs
    localparam logic [1:0] NODE_0 = 2'd0;
    localparam logic [1:0] NODE_1 = 2'd1;
    localparam logic [1:0] NODE_2 = 2'd2;
    localparam logic [1:0] NODE_3 = 2'd3;

    // Processor configure word fields
    localparam int unsigned CFG_REQ     = 0;
    localparam int unsigned CFG_DEST_HI = 2;
    localparam int unsigned CFG_DEST_LO = 1;
    localparam int unsigned CFG_PAY_HI  = 10;
    localparam int unsigned CFG_PAY_LO  = 3;

    // Builds a valid flit; parity is even parity over the payload.
    function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0] dest,
                                                    input logic [1:0] src,
                                                    input logic [3:0] seq,
                                                    input logic [7:0] payload);
        return {1'b1, dest, src, seq, ^payload, payload};
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO with occupancy count; depth must be a power of two.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr_q];
    assign count   = count_q;

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr_q] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/noc_network_interface.sv
// Processor-to-router injection stage: edge-detects send requests, queues them and
// launches formatted flits under a valid/ready handshake with a global stall.
module noc_network_interface
    import noc_pkg::*;
#(
    parameter logic [1:0]  SRC_ID     = 2'd0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CFG_W      = 11,
    parameter int unsigned FLIT_W     = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CFG_W-1:0]  p_configure,
    input  logic              block_all_paths,
    input  logic              router_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              processor_ready,
    output logic              err_overflow,
    output logic              err_self_dest
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic              req_prev_q;
    logic              req_edge, self_hit, ovf_hit, push, load;
    logic [1:0]        req_dest, head_dest;
    logic [7:0]        req_pay, head_pay;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic [FLIT_W-1:0] flit_q;
    logic [3:0]        seq_q;
    logic              err_ovf_q, err_self_q;

    assign req_edge  = p_configure[CFG_REQ] && !req_prev_q;
    assign req_dest  = p_configure[CFG_DEST_HI:CFG_DEST_LO];
    assign req_pay   = p_configure[CFG_PAY_HI:CFG_PAY_LO];
    assign self_hit  = req_edge && (req_dest == SRC_ID);
    // Full is judged on the pre-pop count, so a same-edge pop never rescues a push.
    assign ovf_hit   = req_edge && !self_hit && fifo_full;
    assign push      = req_edge && !self_hit && !fifo_full;

    assign head_dest = fifo_dout[ENTRY_W-1:8];
    assign head_pay  = fifo_dout[7:0];
    assign load      = (!flit_q[FLIT_VALID] || router_ready) && !fifo_empty && !block_all_paths;

    assign flit_out        = flit_q;
    assign processor_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign err_overflow    = err_ovf_q;
    assign err_self_dest   = err_self_q;

    noc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .din   ({req_dest, req_pay}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Request edge history and sticky error flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_prev_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_self_q <= 1'b0;
        end else begin
            req_prev_q <= p_configure[CFG_REQ];
            if (ovf_hit)  err_ovf_q  <= 1'b1;
            if (self_hit) err_self_q <= 1'b1;
        end
    end

    // Output flit register: load from queue head, or retire valid on acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flit_q <= '0;
            seq_q  <= '0;
        end else if (load) begin
            flit_q <= make_flit(head_dest, SRC_ID, seq_q, head_pay);
            seq_q  <= seq_q + 4'd1;
        end else if (flit_q[FLIT_VALID] && router_ready) begin
            flit_q[FLIT_VALID] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_network_interface.sv
// Scoreboard bench for noc_network_interface: stimulus pushes expected flits, a monitor
// pops and compares on every accepted flit and checks the hold-under-backpressure rule.
module tb_noc_network_interface;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] p_configure = '0;
    logic        block_all_paths = 1'b0;
    logic        router_ready = 1'b1;
    logic [17:0] flit_out;
    logic        processor_ready, err_overflow, err_self_dest;

    int checks = 0;
    int failures = 0;
    int accepts = 0;
    logic [17:0] exp_q[$];
    logic        hold_pend = 1'b0;
    logic [17:0] prev_flit = '0;

    noc_network_interface #(
        .SRC_ID     (2'd0),
        .FIFO_DEPTH (4),
        .CFG_W      (11),
        .FLIT_W     (18)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .p_configure     (p_configure),
        .block_all_paths (block_all_paths),
        .router_ready    (router_ready),
        .flit_out        (flit_out),
        .processor_ready (processor_ready),
        .err_overflow    (err_overflow),
        .err_self_dest   (err_self_dest)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent flit builder (source is node 0).
    function automatic logic [17:0] exp_flit(input logic [1:0] d, input logic [3:0] s,
                                             input logic [7:0] p);
        logic par;
        par = 1'b0;
        for (int i = 0; i < 8; i++) par = par ^ p[i];
        return {1'b1, d, 2'b00, s, par, p};
    endfunction

    // Monitor: an accept happens on the next rising edge when valid & ready are seen here.
    always @(negedge clock) begin
        if (reset) begin
            if (hold_pend) check("hold_stable", 32'(flit_out), 32'(prev_flit));
            if (flit_out[17] && router_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", 32'(flit_out), 32'h0);
                end else begin
                    check("flit_value", 32'(flit_out), 32'(exp_q.pop_front()));
                end
            end
            hold_pend = flit_out[17] && !router_ready;
            prev_flit = flit_out;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] d, input logic [7:0] p);
        p_configure = {p, d, 1'b1};
        @(posedge clock);
        #1;
        p_configure[0] = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        exp_q.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int base;

    initial begin
        // Reset state
        @(posedge clock);
        #1;
        check("rst_flit", 32'(flit_out), 32'h0);
        check("rst_err_ovf", 32'(err_overflow), 32'h0);
        check("rst_err_self", 32'(err_self_dest), 32'h0);
        reset = 1'b1;
        cycles(1);
        check("rst_proc_ready", 32'(processor_ready), 32'h1);

        // Single send: flit two cycles after the request, then valid drops
        exp_q.push_back(18'h28101);
        send(2'd1, 8'h01);
        check("single_flit", 32'(flit_out), 32'h28101);
        cycles(1);
        check("single_valid_drop", 32'(flit_out[17]), 32'h0);
        check("single_q_empty", 32'(exp_q.size()), 32'h0);

        // Backpressure: held flit stays put, then three flits on consecutive cycles
        do_reset();
        router_ready = 1'b0;
        exp_q.push_back(18'h28101);
        exp_q.push_back(18'h3025A);
        exp_q.push_back(18'h384C3);
        send(2'd1, 8'h01);
        send(2'd2, 8'h5A);
        send(2'd3, 8'hC3);
        cycles(5);
        check("bp_hold", 32'(flit_out), 32'h28101);
        base = accepts;
        router_ready = 1'b1;
        cycles(3);
        check("bp_burst_count", 32'(accepts - base), 32'd3);
        check("bp_q_empty", 32'(exp_q.size()), 32'h0);

        // Overflow: output blocked, four fill the queue, the fifth is dropped
        do_reset();
        router_ready = 1'b0;
        block_all_paths = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_flit(2'd2, 4'(i), 8'(8'h10 + i)));
            send(2'd2, 8'(8'h10 + i));
            if (i == 2) check("ovf_ready_3", 32'(processor_ready), 32'h1);
        end
        check("ovf_ready_4", 32'(processor_ready), 32'h0);
        check("ovf_err_before", 32'(err_overflow), 32'h0);
        send(2'd2, 8'h14);
        check("ovf_err_after", 32'(err_overflow), 32'h1);
        check("ovf_ready_5", 32'(processor_ready), 32'h0);
        base = accepts;
        block_all_paths = 1'b0;
        router_ready = 1'b1;
        cycles(8);
        check("ovf_flit_count", 32'(accepts - base), 32'd4);
        check("ovf_q_empty", 32'(exp_q.size()), 32'h0);
        check("ovf_err_sticky", 32'(err_overflow), 32'h1);

        // Self-destination request is dropped
        do_reset();
        base = accepts;
        p_configure = 11'b00000001001;
        cycles(1);
        p_configure = '0;
        cycles(4);
        check("self_no_flit", 32'(flit_out[17]), 32'h0);
        check("self_count0", 32'(processor_ready), 32'h1);
        check("self_err", 32'(err_self_dest), 32'h1);
        check("self_no_ovf", 32'(err_overflow), 32'h0);
        check("self_accepts", 32'(accepts - base), 32'd0);

        // Block: nothing launches while stalled, both emerge afterwards with contiguous seq
        do_reset();
        block_all_paths = 1'b1;
        exp_q.push_back(exp_flit(2'd1, 4'd0, 8'hA5));
        exp_q.push_back(exp_flit(2'd3, 4'd1, 8'h3C));
        send(2'd1, 8'hA5);
        send(2'd3, 8'h3C);
        for (int i = 0; i < 5; i++) check("blk_no_valid", 32'(flit_out[17]), 32'h0);
        cycles(5);
        check("blk_no_valid_end", 32'(flit_out[17]), 32'h0);
        base = accepts;
        block_all_paths = 1'b0;
        cycles(4);
        check("blk_flit_count", 32'(accepts - base), 32'd2);
        check("blk_q_empty", 32'(exp_q.size()), 32'h0);

        // Sequence wrap over 17 flits, then asynchronous reset with work in flight
        do_reset();
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(exp_flit(2'd1, 4'(i), 8'(i)));
            send(2'd1, 8'(i));
        end
        cycles(2);
        check("wrap_q_empty", 32'(exp_q.size()), 32'h0);
        router_ready = 1'b0;
        exp_q.push_back(exp_flit(2'd3, 4'd1, 8'hEE));
        send(2'd3, 8'hEE);
        send(2'd2, 8'h11);
        send(2'd2, 8'h22);
        check("pre_rst_valid", 32'(flit_out[17]), 32'h1);
        check("pre_rst_ready", 32'(processor_ready), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_flit", 32'(flit_out), 32'h0);
        exp_q.delete();
        #2;
        reset = 1'b1;
        router_ready = 1'b1;
        cycles(3);
        check("post_rst_no_flit", 32'(flit_out[17]), 32'h0);
        base = accepts;
        exp_q.push_back(18'h30077);
        send(2'd2, 8'h77);
        check("post_rst_seq0", 32'(flit_out), 32'h30077);
        cycles(4);
        check("post_rst_count", 32'(accepts - base), 32'd1);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
